// File: rtl/serial_adder_if.sv
// Bus bundle for the bit-serial adder: request side (start/operands) and
// result side (status flags and registered sum/carry-out).
interface serial_adder_if #(
  parameter int WIDTH = 8
);
  // Handshake: a request is accepted at a rising clk edge where start=1 and
  // ready=1. At that edge a/b/cin are captured. Afterwards they are don't-care.
  // done pulses for one cycle when sum/cout carry the new result.
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             ready;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;

  modport master (
    output start, a, b, cin,
    input  ready, busy, done, sum, cout
  );

  modport slave (
    input  start, a, b, cin,
    output ready, busy, done, sum, cout
  );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial ripple adder: one full-adder cell processes one bit per cycle,
// LSB first. {cout,sum} = a + b + cin after WIDTH shift cycles.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          rst,
  serial_adder_if.slave bus,
  output logic [1:0]    state_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] op_a_q, op_a_d;
  logic [WIDTH-1:0] op_b_q, op_b_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] psum_q, psum_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;

  logic             fa_sum;
  logic             fa_carry;
  logic [WIDTH-1:0] psum_shifted;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      op_a_q  <= '0;
      op_b_q  <= '0;
      carry_q <= 1'b0;
      psum_q  <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_a_q  <= op_a_d;
      op_b_q  <= op_b_d;
      carry_q <= carry_d;
      psum_q  <= psum_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  always_comb begin
    fa_sum       = op_a_q[0] ^ op_b_q[0] ^ carry_q;
    fa_carry     = (op_a_q[0] & op_b_q[0]) | (op_a_q[0] & carry_q) |
                   (op_b_q[0] & carry_q);
    // New bit enters at the MSB; written as shift/or so WIDTH=1 needs no slice.
    psum_shifted = (psum_q >> 1) | (WIDTH'(fa_sum) << (WIDTH - 1));

    state_d = state_q;
    op_a_d  = op_a_q;
    op_b_d  = op_b_q;
    carry_d = carry_q;
    psum_d  = psum_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          state_d = SHIFT;
          op_a_d  = bus.a;
          op_b_d  = bus.b;
          carry_d = bus.cin;
          psum_d  = '0;
          cnt_d   = '0;
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        psum_d  = psum_shifted;
        op_a_d  = op_a_q >> 1;
        op_b_d  = op_b_q >> 1;
        carry_d = fa_carry;
        cnt_d   = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BIT) begin
          state_d = DONE;
          sum_d   = psum_shifted;
          cout_d  = fa_carry;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.ready = (state_q == IDLE) || (state_q == DONE);
  assign bus.busy  = (state_q == SHIFT);
  assign bus.done  = (state_q == DONE);
  assign bus.sum   = sum_q;
  assign bus.cout  = cout_q;
  assign state_o   = state_q;

endmodule
